fft_bfly_pipe: RTL and testbench

- Parametrised, fully pipelined radix-2 DIF butterfly with twiddle multiply; the stage engine of the next-generation batch FFT.
- Replaces the fixed 18-bit, two-deep valid-gated V0 pipe with generic widths, a ready/valid stall, per-sample scaling, rounding and saturation.
- Instantiated once per FFT stage (log2 N instances) between the stage reorder buffers.

---
 rtl/fft_pkg.sv | 32 +++
 rtl/fft_cmul_rnd.sv | 88 ++++++++
 rtl/fft_bfly_pipe.sv | 105 ++++++++++
 tb/tb_fft_bfly_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared widths and arithmetic helpers for the FFT stage engines.
// Helpers work on 64-bit signed values so every stage can reuse them at any width.
package fft_pkg;

  localparam int DATA_W_DEF = 18;
  localparam int TW_W_DEF   = 18;

  // Twiddles are Q2.(TW_W-2): +1.0 is 2^(TW_W-2).
  function automatic int tw_frac(input int tw_w);
    return tw_w - 2;
  endfunction

  function automatic logic signed [63:0] rnd_shr(input logic signed [63:0] v, input int sh);
    if (sh <= 0) return v;
    return (v + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic is_clamped(input logic signed [63:0] v, input int w);
    return sat_w(v, w) != v;
  endfunction

endpackage

// File: rtl/fft_cmul_rnd.sv
// S3-S4 slice: complex twiddle multiply, half-up rounding, optional /2 and saturation.
// clamp is combinational: the beat sitting in S3 will saturate when it moves into S4.
module fft_cmul_rnd import fft_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TW_W   = TW_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic                     scale,
  input  logic signed [DATA_W:0]   s_re,
  input  logic signed [DATA_W:0]   s_im,
  input  logic signed [DATA_W:0]   d_re,
  input  logic signed [DATA_W:0]   d_im,
  input  logic signed [TW_W-1:0]   w_re,
  input  logic signed [TW_W-1:0]   w_im,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] x_re,
  output logic signed [DATA_W-1:0] x_im,
  output logic signed [DATA_W-1:0] y_re,
  output logic signed [DATA_W-1:0] y_im,
  output logic                     clamp
);

  localparam int PW = DATA_W + TW_W + 1;
  localparam int FB = tw_frac(TW_W);

  logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;
  logic signed [DATA_W:0]   s3_s_re, s3_s_im;
  logic                     s3_scale;
  logic                     s3_valid;
  logic signed [63:0]       xr, xi, yr, yi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_rr     <= '0;
      p_ii     <= '0;
      p_ri     <= '0;
      p_ir     <= '0;
      s3_s_re  <= '0;
      s3_s_im  <= '0;
      s3_scale <= 1'b0;
      s3_valid <= 1'b0;
    end else if (en) begin
      p_rr     <= PW'(d_re) * PW'(w_re);
      p_ii     <= PW'(d_im) * PW'(w_im);
      p_ri     <= PW'(d_re) * PW'(w_im);
      p_ir     <= PW'(d_im) * PW'(w_re);
      s3_s_re  <= s_re;
      s3_s_im  <= s_im;
      s3_scale <= scale;
      s3_valid <= in_valid;
    end
  end

  always_comb begin
    xr = 64'(s3_s_re);
    xi = 64'(s3_s_im);
    yr = rnd_shr(64'(p_rr) - 64'(p_ii), FB);
    yi = rnd_shr(64'(p_ri) + 64'(p_ir), FB);
    if (s3_scale) begin
      xr = rnd_shr(xr, 1);
      xi = rnd_shr(xi, 1);
      yr = rnd_shr(yr, 1);
      yi = rnd_shr(yi, 1);
    end
    clamp = s3_valid && (is_clamped(xr, DATA_W) || is_clamped(xi, DATA_W) ||
                         is_clamped(yr, DATA_W) || is_clamped(yi, DATA_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_re      <= '0;
      x_im      <= '0;
      y_re      <= '0;
      y_im      <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      x_re      <= DATA_W'(sat_w(xr, DATA_W));
      x_im      <= DATA_W'(sat_w(xi, DATA_W));
      y_re      <= DATA_W'(sat_w(yr, DATA_W));
      y_im      <= DATA_W'(sat_w(yi, DATA_W));
      out_valid <= s3_valid;
    end
  end

endmodule

// File: rtl/fft_bfly_pipe.sv
// Radix-2 DIF butterfly stage: X = A+B, Y = (A-B)*W, four register stages, one global stall.
// Handshake: a beat moves on every edge where en = !o_u1_valid || i_u1_ready; o_u1_ready = en.
module fft_bfly_pipe import fft_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TW_W   = TW_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_u1_valid,
  output logic                     o_u1_ready,
  input  logic                     i_u1_scale,
  input  logic signed [DATA_W-1:0] i_s_a_re,
  input  logic signed [DATA_W-1:0] i_s_a_im,
  input  logic signed [DATA_W-1:0] i_s_b_re,
  input  logic signed [DATA_W-1:0] i_s_b_im,
  input  logic signed [TW_W-1:0]   i_s_w_re,
  input  logic signed [TW_W-1:0]   i_s_w_im,
  output logic                     o_u1_valid,
  input  logic                     i_u1_ready,
  output logic signed [DATA_W-1:0] o_s_x_re,
  output logic signed [DATA_W-1:0] o_s_x_im,
  output logic signed [DATA_W-1:0] o_s_y_re,
  output logic signed [DATA_W-1:0] o_s_y_im,
  output logic                     o_u1_ovf,
  input  logic                     i_u1_ovf_clr
);

  localparam int SW = DATA_W + 1;

  logic                     en;
  logic                     clamp;
  logic signed [DATA_W-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im;
  logic signed [TW_W-1:0]   s1_w_re, s1_w_im, s2_w_re, s2_w_im;
  logic                     s1_scale, s1_valid, s2_scale, s2_valid;
  logic signed [SW-1:0]     s2_s_re, s2_s_im, s2_d_re, s2_d_im;

  assign en         = !o_u1_valid || i_u1_ready;
  assign o_u1_ready = en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a_re  <= '0;
      s1_a_im  <= '0;
      s1_b_re  <= '0;
      s1_b_im  <= '0;
      s1_w_re  <= '0;
      s1_w_im  <= '0;
      s1_scale <= 1'b0;
      s1_valid <= 1'b0;
      s2_s_re  <= '0;
      s2_s_im  <= '0;
      s2_d_re  <= '0;
      s2_d_im  <= '0;
      s2_w_re  <= '0;
      s2_w_im  <= '0;
      s2_scale <= 1'b0;
      s2_valid <= 1'b0;
    end else if (en) begin
      s1_a_re  <= i_s_a_re;
      s1_a_im  <= i_s_a_im;
      s1_b_re  <= i_s_b_re;
      s1_b_im  <= i_s_b_im;
      s1_w_re  <= i_s_w_re;
      s1_w_im  <= i_s_w_im;
      s1_scale <= i_u1_scale;
      s1_valid <= i_u1_valid;
      s2_s_re  <= SW'(s1_a_re) + SW'(s1_b_re);
      s2_s_im  <= SW'(s1_a_im) + SW'(s1_b_im);
      s2_d_re  <= SW'(s1_a_re) - SW'(s1_b_re);
      s2_d_im  <= SW'(s1_a_im) - SW'(s1_b_im);
      s2_w_re  <= s1_w_re;
      s2_w_im  <= s1_w_im;
      s2_scale <= s1_scale;
      s2_valid <= s1_valid;
    end
  end

  fft_cmul_rnd #(.DATA_W(DATA_W), .TW_W(TW_W)) u_cmul (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (s2_valid),
    .scale     (s2_scale),
    .s_re      (s2_s_re),
    .s_im      (s2_s_im),
    .d_re      (s2_d_re),
    .d_im      (s2_d_im),
    .w_re      (s2_w_re),
    .w_im      (s2_w_im),
    .out_valid (o_u1_valid),
    .x_re      (o_s_x_re),
    .x_im      (o_s_x_im),
    .y_re      (o_s_y_re),
    .y_im      (o_s_y_im),
    .clamp     (clamp)
  );

  // A clamping beat landing in S4 beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_u1_ovf <= 1'b0;
    else if (en && clamp) o_u1_ovf <= 1'b1;
    else if (i_u1_ovf_clr) o_u1_ovf <= 1'b0;
  end

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// Bench for fft_bfly_pipe: directed butterfly cases plus random stream with stalls,
// checked against an arithmetic reference of the butterfly equations.
module tb_fft_bfly_pipe;

  localparam int DW = 18;
  localparam int TWW = 18;
  localparam int EW = 4 * DW + 1;
  localparam longint Q = longint'(1) << (TWW - 2);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 i_u1_valid = 1'b0;
  logic                 o_u1_ready;
  logic                 i_u1_scale = 1'b0;
  logic signed [DW-1:0] i_s_a_re = '0, i_s_a_im = '0, i_s_b_re = '0, i_s_b_im = '0;
  logic signed [TWW-1:0] i_s_w_re = '0, i_s_w_im = '0;
  logic                 o_u1_valid;
  logic                 i_u1_ready = 1'b1;
  logic signed [DW-1:0] o_s_x_re, o_s_x_im, o_s_y_re, o_s_y_im;
  logic                 o_u1_ovf;
  logic                 i_u1_ovf_clr = 1'b0;

  fft_bfly_pipe #(.DATA_W(DW), .TW_W(TWW)) dut (
    .clk(clk), .rst(rst),
    .i_u1_valid(i_u1_valid), .o_u1_ready(o_u1_ready), .i_u1_scale(i_u1_scale),
    .i_s_a_re(i_s_a_re), .i_s_a_im(i_s_a_im), .i_s_b_re(i_s_b_re), .i_s_b_im(i_s_b_im),
    .i_s_w_re(i_s_w_re), .i_s_w_im(i_s_w_im),
    .o_u1_valid(o_u1_valid), .i_u1_ready(i_u1_ready),
    .o_s_x_re(o_s_x_re), .o_s_x_im(o_s_x_im), .o_s_y_re(o_s_y_re), .o_s_y_im(o_s_y_im),
    .o_u1_ovf(o_u1_ovf), .i_u1_ovf_clr(i_u1_ovf_clr)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic longint fdiv(input longint n, input longint q);
    if (n >= 0) return n / q;
    return -((-n + q - 1) / q);
  endfunction

  function automatic longint rnd_half_up(input longint v, input longint q);
    return fdiv(v + q / 2, q);
  endfunction

  function automatic logic [EW-1:0] model(input longint are, input longint aim,
                                          input longint bre, input longint bim,
                                          input longint wre, input longint wim,
                                          input logic sc);
    longint v[4];
    longint hi, lo;
    logic c;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -hi - 1;
    v[0] = are + bre;
    v[1] = aim + bim;
    v[2] = rnd_half_up((are - bre) * wre - (aim - bim) * wim, Q);
    v[3] = rnd_half_up((are - bre) * wim + (aim - bim) * wre, Q);
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (sc) v[i] = rnd_half_up(v[i], 2);
      if (v[i] > hi) begin v[i] = hi; c = 1'b1; end
      else if (v[i] < lo) begin v[i] = lo; c = 1'b1; end
    end
    return {c, v[0][DW-1:0], v[1][DW-1:0], v[2][DW-1:0], v[3][DW-1:0]};
  endfunction

  // scoreboard
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] cur = '0;
  logic          prev_en = 1'b1;
  logic          clr_edge = 1'b0;
  logic          exp_ovf = 1'b0;
  int            n_got = 0;

  task automatic compare_beat(input string p, input logic [EW-1:0] e);
    check({p, "_x_re"}, longint'(o_s_x_re), longint'($signed(e[4*DW-1:3*DW])));
    check({p, "_x_im"}, longint'(o_s_x_im), longint'($signed(e[3*DW-1:2*DW])));
    check({p, "_y_re"}, longint'(o_s_y_re), longint'($signed(e[2*DW-1:DW])));
    check({p, "_y_im"}, longint'(o_s_y_im), longint'($signed(e[DW-1:0])));
  endtask

  always @(posedge clk) clr_edge = i_u1_ovf_clr;

  always @(negedge clk) begin
    logic fresh;
    logic c;
    if (rst) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      prev_en = 1'b1;
      check("rst_valid", o_u1_valid, 0);
    end else begin
      check("ready_rule", o_u1_ready, !o_u1_valid || i_u1_ready);
      fresh = prev_en && o_u1_valid;
      c = 1'b0;
      if (fresh) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          c = cur[EW-1];
          n_got++;
          compare_beat("beat", cur);
        end
      end else if (o_u1_valid) begin
        compare_beat("hold", cur);
      end
      exp_ovf = (fresh && c) || (exp_ovf && !clr_edge);
      check("ovf", o_u1_ovf, exp_ovf);
      if (i_u1_valid && o_u1_ready)
        exp_q.push_back(model(i_s_a_re, i_s_a_im, i_s_b_re, i_s_b_im,
                              i_s_w_re, i_s_w_im, i_u1_scale));
      prev_en = o_u1_ready;
    end
  end

  // drivers
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic put_beat(input longint ar, input longint ai, input longint br, input longint bi,
                          input longint wr, input longint wi, input logic sc);
    i_s_a_re = ar[DW-1:0];
    i_s_a_im = ai[DW-1:0];
    i_s_b_re = br[DW-1:0];
    i_s_b_im = bi[DW-1:0];
    i_s_w_re = wr[TWW-1:0];
    i_s_w_im = wi[TWW-1:0];
    i_u1_scale = sc;
    i_u1_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (o_u1_ready) break;
    end
    check("accept_timeout", o_u1_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_u1_valid = 1'b0;
  endtask

  task automatic wait_beat(output int n);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      n++;
      if (o_u1_valid) break;
    end
    check("beat_timeout", o_u1_valid, 1);
  endtask

  function automatic longint rnd_s(input int w);
    logic [31:0] r;
    r = $urandom;
    return longint'($signed(r)) >>> (32 - w);
  endfunction

  function automatic longint rnd_val(input int w);
    if ($urandom_range(0, 1) == 0) return longint'($urandom_range(0, 2000)) - 1000;
    return rnd_s(w);
  endfunction

  initial begin
    int n;
    int got0;
    int seen;
    logic take;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", o_u1_valid, 0);
    check("reset_x_re", o_s_x_re, 0);
    check("reset_y_im", o_s_y_im, 0);
    check("reset_ovf", o_u1_ovf, 0);
    check("reset_ready", o_u1_ready, 1);
    sync();
    rst = 1'b0;
    sync();

    // basic butterfly, W = +1.0
    put_beat(100, -50, 20, 30, 65536, 0, 0);
    idle();
    wait_beat(n);
    check("latency", n, 4);
    check("t1_x_re", o_s_x_re, 120);
    check("t1_x_im", o_s_x_im, -20);
    check("t1_y_re", o_s_y_re, 80);
    check("t1_y_im", o_s_y_im, -80);
    @(negedge clk);
    check("t1_pulse_once", o_u1_valid, 0);

    // W = -j, then with scaling
    sync();
    put_beat(100, -50, 20, 30, 0, -65536, 0);
    put_beat(100, -50, 20, 30, 0, -65536, 1);
    idle();
    wait_beat(n);
    check("t2_y_re", o_s_y_re, -80);
    check("t2_y_im", o_s_y_im, -80);
    @(negedge clk);
    check("t3_x_re", o_s_x_re, 60);
    check("t3_x_im", o_s_x_im, -10);
    check("t3_y_re", o_s_y_re, -40);
    check("t3_y_im", o_s_y_im, -40);

    // half-up rounding at W = 0.5
    sync();
    put_beat(3, 0, 0, 0, 32768, 0, 0);
    put_beat(-3, 0, 0, 0, 32768, 0, 0);
    idle();
    wait_beat(n);
    check("rnd_pos_y_re", o_s_y_re, 2);
    @(negedge clk);
    check("rnd_neg_y_re", o_s_y_re, -1);

    // saturation, sticky flag, set beats clear
    sync();
    put_beat(131071, 0, 131071, 0, 65536, 0, 0);
    put_beat(131071, 0, 131071, 0, 65536, 0, 0);
    idle();
    wait_beat(n);
    check("sat_x_re", o_s_x_re, 131071);
    check("sat_ovf", o_u1_ovf, 1);
    #1 i_u1_ovf_clr = 1'b1;
    @(negedge clk);
    check("ovf_set_wins", o_u1_ovf, 1);
    check("sat2_x_re", o_s_x_re, 131071);
    @(negedge clk);
    check("ovf_cleared", o_u1_ovf, 0);
    #1 i_u1_ovf_clr = 1'b0;

    // 8-beat stream with a 3-cycle downstream stall
    sync();
    got0 = n_got;
    fork
      begin
        for (int i = 0; i < 8; i++)
          put_beat(rnd_val(DW), rnd_val(DW), rnd_val(DW), rnd_val(DW),
                   rnd_s(TWW), rnd_s(TWW), 1'($urandom_range(0, 1)));
        idle();
      end
      begin
        repeat (5) @(posedge clk);
        #1 i_u1_ready = 1'b0;
        @(negedge clk);
        check("stall_valid", o_u1_valid, 1);
        check("stall_ready", o_u1_ready, 0);
        repeat (3) @(posedge clk);
        #1 i_u1_ready = 1'b1;
      end
    join
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) @(negedge clk);
    check("stall_delivered", n_got - got0, 8);

    // reset with three beats in flight
    sync();
    put_beat(500, 600, -700, 800, 40000, -20000, 0);
    put_beat(-500, 60, 70, -80, 1000, 2000, 1);
    put_beat(5, 6, 7, 8, 65536, 65536, 0);
    idle();
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", o_u1_valid, 0);
    check("rst_x_re", o_s_x_re, 0);
    check("rst_x_im", o_s_x_im, 0);
    check("rst_y_re", o_s_y_re, 0);
    check("rst_y_im", o_s_y_im, 0);
    check("rst_ovf", o_u1_ovf, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_u1_valid) seen++;
    end
    check("no_stale_beat", seen, 0);

    // random stream with random stalls and clears
    sync();
    take = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (take) begin
        i_s_a_re = rnd_val(DW);
        i_s_a_im = rnd_val(DW);
        i_s_b_re = rnd_val(DW);
        i_s_b_im = rnd_val(DW);
        i_s_w_re = rnd_s(TWW);
        i_s_w_im = rnd_s(TWW);
        i_u1_scale = 1'($urandom_range(0, 1));
        i_u1_valid = ($urandom_range(0, 3) != 0);
      end
      i_u1_ready = ($urandom_range(0, 3) != 0);
      i_u1_ovf_clr = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      take = !i_u1_valid || o_u1_ready;
      sync();
    end
    idle();
    i_u1_ready = 1'b1;
    i_u1_ovf_clr = 1'b0;
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
